// File: rtl/gap_tv_pkg.sv
// Shared GAP-TV datapath definitions: fp16 field layout, frame geometry defaults,
// and the frame-level FSM state type.
package gap_tv_pkg;

  localparam int FP16_W        = 16;
  localparam int LANES_DEF     = 32;
  localparam int COL_WIDTH_DEF = 2;
  localparam int ROW_NUM_DEF   = 48;

  localparam logic [FP16_W-1:0] FP16_POS_ZERO = 16'h0000;

  localparam int FP16_SIGN_BIT = 15;
  localparam int FP16_EXP_MSB  = 14;
  localparam int FP16_EXP_LSB  = 10;
  localparam int FP16_MAN_MSB  = 9;
  localparam int FP16_MAN_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } tv_state_t;

endpackage

// File: rtl/fp16_clip_lane.sv
// Clamps one fp16 lane to [-lim, +lim]; NaN collapses to +0, -0 passes through.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module fp16_clip_lane
  import gap_tv_pkg::*;
(
  input  logic [FP16_W-1:0] x,
  input  logic [FP16_W-2:0] lim,
  output logic [FP16_W-1:0] y,
  output logic              clipped
);

  logic is_nan;

  assign is_nan = (&x[FP16_EXP_MSB:FP16_EXP_LSB]) && (|x[FP16_MAN_MSB:FP16_MAN_LSB]);

  // Magnitude bits of fp16 order like unsigned integers, so Inf falls out of the compare.
  always_comb begin
    y       = x;
    clipped = 1'b0;
    if (is_nan) begin
      y       = FP16_POS_ZERO;
      clipped = 1'b1;
    end else if (x[FP16_W-2:0] > lim) begin
      y       = {x[FP16_SIGN_BIT], lim};
      clipped = 1'b1;
    end
  end

endmodule

// File: rtl/tv_clip_writeback.sv
// Chambolle dual projection + BRAM writeback; clip_count stats only with TV_CLIP_STATS_EN.
// Latency: accepted beat -> wen two cycles later when wr_ready stays high.
// Backpressure: wr_ready low freezes both stages and drops in_ready once stage 2 is full.
module tv_clip_writeback
  import gap_tv_pkg::*;
#(
  parameter int LANES     = LANES_DEF,
  parameter int COL_WIDTH = COL_WIDTH_DEF,
  parameter int ROW_NUM   = ROW_NUM_DEF,
  parameter int ADDR_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [FP16_W-1:0]       lambda,
  input  logic                    in_valid,
  input  logic [LANES*FP16_W-1:0] in_data,
  output logic                    in_ready,
  input  logic                    wr_ready,
  output logic                    wen,
  output logic [ADDR_W-1:0]       waddr,
  output logic [LANES*FP16_W-1:0] dout,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             clip_count
);

  localparam int TOTAL = ROW_NUM * COL_WIDTH;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int ROW_W = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
  localparam int COL_W = (COL_WIDTH > 1) ? $clog2(COL_WIDTH) : 1;

  tv_state_t                 state, state_nxt;
  logic [FP16_W-2:0]         lam;
  logic [CNT_W-1:0]          accepted;
  logic [ROW_W-1:0]          row;
  logic [COL_W-1:0]          col;
  logic                      s1_valid, s2_valid;
  logic [LANES*FP16_W-1:0]   s1_data, s2_data, clip_data;
  logic [LANES-1:0]          clip_vec;
  logic                      pipe_en, accept, start_acc, last_beat, wr_done;
  logic                      unused_lambda_sign;

  assign unused_lambda_sign = lambda[FP16_SIGN_BIT];

  assign start_acc = start && (state == IDLE);
  assign pipe_en   = !s2_valid || wr_ready;
  assign in_ready  = (state == RUN) && pipe_en && (accepted < CNT_W'(TOTAL));
  assign accept    = in_valid && in_ready;
  assign last_beat = accept && (accepted == CNT_W'(TOTAL - 1));
  assign wr_done   = s2_valid && wr_ready;

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign wen   = s2_valid;
  assign dout  = s2_data;
  assign waddr = s2_valid ? ADDR_W'(int'(row) * COL_WIDTH + int'(col)) : '0;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fp16_clip_lane u_lane (
      .x       (in_data[g*FP16_W +: FP16_W]),
      .lim     (lam),
      .y       (clip_data[g*FP16_W +: FP16_W]),
      .clipped (clip_vec[g])
    );
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_beat) state_nxt = DRAIN;
      DRAIN:   if (!s1_valid && !s2_valid) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address counter tracks the beat sitting in stage 2, so it only moves on a completed write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      lam      <= '0;
      accepted <= '0;
      row      <= '0;
      col      <= COL_W'(COL_WIDTH - 1);
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        lam      <= lambda[FP16_W-2:0];
        accepted <= '0;
        row      <= '0;
        col      <= COL_W'(COL_WIDTH - 1);
      end else begin
        if (accept) accepted <= accepted + 1'b1;
        if (wr_done) begin
          if (col != '0) begin
            col <= col - 1'b1;
          end else begin
            col <= COL_W'(COL_WIDTH - 1);
            row <= (row == ROW_W'(ROW_NUM - 1)) ? '0 : row + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_data  <= '0;
      s2_data  <= '0;
    end else if (pipe_en) begin
      s1_valid <= accept;
      if (accept) s1_data <= clip_data;
      s2_valid <= s1_valid;
      if (s1_valid) s2_data <= s1_data;
    end
  end

`ifdef TV_CLIP_STATS_EN
  localparam int PC_W = $clog2(LANES + 1);

  logic [PC_W-1:0] n_clip;
  logic [16:0]     cc_sum;
  logic [15:0]     cc_q;

  always_comb begin
    n_clip = '0;
    for (int i = 0; i < LANES; i++) n_clip = n_clip + PC_W'(clip_vec[i]);
  end

  assign cc_sum = {1'b0, cc_q} + 17'(n_clip);

  always_ff @(posedge clk) begin
    if (!rst_n)         cc_q <= '0;
    else if (start_acc) cc_q <= '0;
    else if (accept)    cc_q <= cc_sum[16] ? 16'hFFFF : cc_sum[15:0];
  end

  assign clip_count = cc_q;
`else
  logic unused_clip_vec;
  assign unused_clip_vec = ^clip_vec;
  assign clip_count      = '0;
`endif

endmodule

// File: tb/tb_tv_clip_writeback.sv
// Directed bench for tv_clip_writeback: clip rule, full frames with and without
// write backpressure, lambda latching and mid-frame reset.
module tb_tv_clip_writeback;

  localparam int NB = 96;
`ifdef TV_CLIP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [15:0]  lambda;
  logic         in_valid;
  logic [511:0] in_data;
  logic         in_ready;
  logic         wr_ready;
  logic         wen;
  logic [7:0]   waddr;
  logic [511:0] dout;
  logic         busy;
  logic         done;
  logic [15:0]  clip_count;

  int n_assert = 0;
  int n_fail   = 0;

  tv_clip_writeback dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .lambda     (lambda),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .wr_ready   (wr_ready),
    .wen        (wen),
    .waddr      (waddr),
    .dout       (dout),
    .busy       (busy),
    .done       (done),
    .clip_count (clip_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rep4(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c, input logic [15:0] d);
    logic [511:0] v;
    for (int i = 0; i < 32; i++)
      case (i % 4)
        0:       v[i*16 +: 16] = a;
        1:       v[i*16 +: 16] = b;
        2:       v[i*16 +: 16] = c;
        default: v[i*16 +: 16] = d;
      endcase
    return v;
  endfunction

  // Frame beats: small positive values pass lambda=1.0; lane 31 is +inf and clips.
  function automatic logic [511:0] beat(input int k, input bit clipped);
    logic [511:0] v;
    for (int i = 0; i < 32; i++)
      v[i*16 +: 16] = (i == 31) ? (clipped ? 16'h3C00 : 16'h7C00) : 16'(k * 32 + i);
    return v;
  endfunction

  function automatic logic [15:0] cc_exp(input int n);
    return STATS ? 16'(n) : 16'h0000;
  endfunction

  task automatic start_frame(input logic [15:0] lam);
    @(negedge clk);
    start = 1'b1; lambda = lam; in_valid = 1'b1; in_data = beat(0, 1'b0);
    #1;
    chk("start_no_accept", 512'(in_ready), 512'(0));
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    #1;
    chk("start_busy", 512'(busy), 512'(1));
  endtask

  // Single isolated beat with wr_ready high: wen two cycles after accept.
  task automatic beat_and_check(input string tag, input logic [511:0] din,
                                input logic [511:0] dexp, input logic [7:0] aexp);
    @(negedge clk);
    in_valid = 1'b1; in_data = din;
    #1;
    chk({tag, "_rdy"}, 512'(in_ready), 512'(1));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk({tag, "_wen_early"}, 512'(wen), 512'(0));
    @(negedge clk);
    #1;
    chk({tag, "_wen"}, 512'(wen), 512'(1));
    chk({tag, "_dout"}, dout, dexp);
    chk({tag, "_waddr"}, 512'(waddr), 512'(aexp));
  endtask

  task automatic run_frame(input string tag, input bit stall);
    int sent = 0, wr = 0, dn = 0, fa = -1, fw = -1;
    start_frame(16'h3C00);
    for (int c = 0; c < 1000 && dn == 0; c++) begin
      @(negedge clk);
      in_valid = (sent < NB);
      in_data  = beat(sent, 1'b0);
      wr_ready = stall ? ((c % 4 == 1) || (c % 4 == 2) ? 1'b0 : 1'b1) : 1'b1;
      #1;
      if (wen) begin
        chk({tag, "_waddr"}, 512'(waddr), 512'(wr ^ 1));
        chk({tag, "_dout"}, dout, beat(wr, 1'b1));
        if (!wr_ready) chk({tag, "_stall_in_ready"}, 512'(in_ready), 512'(0));
        if (fw < 0) fw = c;
        if (wr_ready) wr++;
      end
      if (in_valid && in_ready) begin
        if (fa < 0) fa = c;
        sent++;
      end
      if (done) begin
        dn++;
        chk({tag, "_busy_with_done"}, 512'(busy), 512'(1));
      end
    end
    @(negedge clk);
    in_valid = 1'b1; wr_ready = 1'b1;
    #1;
    chk({tag, "_done_count"}, 512'(dn), 512'(1));
    chk({tag, "_post_done"}, 512'(done), 512'(0));
    chk({tag, "_post_busy"}, 512'(busy), 512'(0));
    chk({tag, "_idle_in_ready"}, 512'(in_ready), 512'(0));
    chk({tag, "_writes"}, 512'(wr), 512'(NB));
    chk({tag, "_beats"}, 512'(sent), 512'(NB));
    chk({tag, "_clip_count"}, 512'(clip_count), 512'(cc_exp(NB)));
    if (!stall) chk({tag, "_latency"}, 512'(fw - fa), 512'(2));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk({tag, "_idle_wen"}, 512'(wen), 512'(0));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; lambda = 16'h0000; in_valid = 1'b0;
    in_data = '0; wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 512'(in_ready), 512'(0));
    chk("rst_wen", 512'(wen), 512'(0));
    chk("rst_waddr", 512'(waddr), 512'(0));
    chk("rst_dout", dout, 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_done", 512'(done), 512'(0));
    chk("rst_clip_count", 512'(clip_count), 512'(0));
    rst_n = 1'b1;

    // Pass / clip / inf / NaN lanes against lambda = 1.0
    start_frame(16'h3C00);
    beat_and_check("basic0", rep4(16'h3800, 16'hC000, 16'h7C00, 16'h7E01),
                   rep4(16'h3800, 16'hBC00, 16'h3C00, 16'h0000), 8'd1);
    beat_and_check("basic1", rep4(16'h3800, 16'hC000, 16'h7C00, 16'h7E01),
                   rep4(16'h3800, 16'hBC00, 16'h3C00, 16'h0000), 8'd0);
    chk("basic_clip_count", 512'(clip_count), 512'(cc_exp(48)));

    // Stream up to beat 40, then reset mid-frame
    for (int n = 2; n < 40; n++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = beat(n, 1'b0);
      #1;
      chk("stream_rdy", 512'(in_ready), 512'(1));
    end
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_wen", 512'(wen), 512'(0));
    chk("midrst_busy", 512'(busy), 512'(0));
    chk("midrst_waddr", 512'(waddr), 512'(0));
    chk("midrst_clip_count", 512'(clip_count), 512'(0));
    rst_n = 1'b1;

    run_frame("frame", 1'b0);
    run_frame("bp", 1'b1);

    // lambda = 0, and a start during RUN must not relatch lambda
    start_frame(16'h0000);
    beat_and_check("lam0_a", rep4(16'h8001, 16'h0001, 16'h8001, 16'h0001),
                   rep4(16'h8000, 16'h0000, 16'h8000, 16'h0000), 8'd1);
    @(negedge clk);
    start = 1'b1; lambda = 16'h3C00;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("run_start_busy", 512'(busy), 512'(1));
    beat_and_check("lam0_b", rep4(16'h8001, 16'h3800, 16'h8000, 16'h0000),
                   rep4(16'h8000, 16'h0000, 16'h8000, 16'h0000), 8'd0);
    chk("lam0_clip_count", 512'(clip_count), 512'(cc_exp(48)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
